// File: rtl/action_arbiter.sv
// Round-robin share of one action/reward agent between CLIENTS environment clients.
// Latency: grant registered 1 cycle after request in IDLE; action/reward paths are zero-latency pass-through.
// Backpressure: agent/client ready signals pass straight through to the granted client; REWARD waits for the client
// unless ACTION_ARBITER_TIMEOUT_EN is defined, in which case a PENALTY reward is injected after TIMEOUT cycles.
module action_arbiter #(
  parameter int unsigned CLIENTS = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  PENALTY = 8'h80
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [CLIENTS-1:0]     client_req,
  output logic [CLIENTS-1:0]     client_grant,
  input  logic                   agent_action_valid,
  input  logic [7:0]             agent_action_data,
  output logic                   agent_action_ready,
  output logic                   agent_action_gready,
  output logic                   agent_reward_valid,
  output logic [7:0]             agent_reward_data,
  input  logic                   agent_reward_ready,
  output logic [CLIENTS-1:0]     client_action_valid,
  output logic [7:0]             client_action_data,
  input  logic [CLIENTS-1:0]     client_action_ready,
  input  logic [CLIENTS-1:0]     client_action_gready,
  input  logic [CLIENTS-1:0]     client_reward_valid,
  input  logic [8*CLIENTS-1:0]   client_reward_data,
  output logic [CLIENTS-1:0]     client_reward_ready
);

  localparam int IDX_W = $clog2(CLIENTS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTION = 2'd1,
    ST_REWARD = 2'd2
  } state_e;

  // Transaction state; last_q doubles as the index of the current grant
  state_e             state_q, state_d;
  logic [CLIENTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;

  // Arbitration result
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [CLIENTS-1:0] win_oh;

  // Granted-client views of the per-client inputs
  logic               g_act_rdy;
  logic               g_gready;
  logic               g_rew_vld;
  logic [7:0]         g_rew_dat;

  logic               in_action;
  logic               in_reward;
  logic               act_hs;
  logic               rew_hs;
  logic               pen_act;

  assign in_action = (state_q == ST_ACTION);
  assign in_reward = (state_q == ST_REWARD);

  // Round-robin search: first requester after the previous winner, wrapping around
  always_comb begin : arb_search
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = last_q;
    for (int k = 1; k <= int'(CLIENTS); k++) begin
      idx = (int'(last_q) + k) % int'(CLIENTS);
      if (!win_vld && client_req[IDX_W'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  // One-hot form of the winner for the grant register
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < int'(CLIENTS); i++) begin
      win_oh[i] = (win_idx == IDX_W'(i));
    end
  end

  // Select the granted client's reward byte; grant is one-hot so at most one term hits
  always_comb begin
    g_rew_dat = 8'h00;
    for (int i = 0; i < int'(CLIENTS); i++) begin
      if (grant_q[i]) begin
        g_rew_dat = client_reward_data[8*i +: 8];
      end
    end
  end

  assign g_act_rdy = |(grant_q & client_action_ready);
  assign g_gready  = |(grant_q & client_action_gready);
  assign g_rew_vld = |(grant_q & client_reward_valid);

  assign act_hs = in_action & agent_action_valid & g_act_rdy;
  assign rew_hs = agent_reward_valid & agent_reward_ready;

`ifdef ACTION_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  // Saturating REWARD-cycle counter and sticky penalty flag
  logic [15:0] cnt_q, cnt_d;
  logic        pen_q, pen_d;
  logic        timed_out;

  // Counter reaching TIMEOUT injects the penalty, unless the client reward is already valid that cycle;
  // once injected the penalty stays until the agent takes it.
  assign timed_out = (cnt_q >= TMO);
  assign pen_act   = in_reward & (pen_q | (timed_out & ~g_rew_vld));

  // Counter clears while in ACTION so it starts from zero on REWARD entry
  always_comb begin
    cnt_d = cnt_q;
    pen_d = pen_q;
    if (in_action) begin
      cnt_d = 16'd0;
      pen_d = 1'b0;
    end else if (in_reward) begin
      if (!rew_hs && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
      pen_d = pen_act & ~rew_hs;
    end
  end

  // Timeout state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
      pen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pen_q <= pen_d;
    end
  end
`else
  // Without the timeout feature REWARD waits for the client indefinitely
  assign pen_act = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, advance on the action and reward handshakes
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_ACTION;
          grant_d = win_oh;
          last_d  = win_idx;
        end
      end
      ST_ACTION: begin
        if (act_hs) begin
          state_d = ST_REWARD;
        end
      end
      ST_REWARD: begin
        if (rew_hs) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM registers; last starts at CLIENTS-1 so client 0 wins the first arbitration
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(CLIENTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Pass-through steering; everything is gated by state so outputs drop with an async reset
  always_comb begin
    client_grant        = grant_q;
    agent_action_gready = g_gready;
    agent_action_ready  = 1'b0;
    agent_reward_valid  = 1'b0;
    agent_reward_data   = 8'h00;
    client_action_valid = '0;
    client_action_data  = 8'h00;
    client_reward_ready = '0;
    if (in_action) begin
      client_action_data  = agent_action_data;
      agent_action_ready  = g_act_rdy;
      client_action_valid = agent_action_valid ? grant_q : '0;
    end else if (in_reward) begin
      client_action_data = agent_action_data;
      if (pen_act) begin
        agent_reward_valid = 1'b1;
        agent_reward_data  = PENALTY;
      end else begin
        agent_reward_valid  = g_rew_vld;
        agent_reward_data   = g_rew_dat;
        client_reward_ready = agent_reward_ready ? grant_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_action_arbiter.sv
// Bench for action_arbiter: directed scenarios plus randomized transactions checked against
// a round-robin reference that tracks only the previous winner and derives every expected output.
module tb_action_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   client_req;
  logic [N-1:0]   client_grant;
  logic           agent_action_valid;
  logic [7:0]     agent_action_data;
  logic           agent_action_ready;
  logic           agent_action_gready;
  logic           agent_reward_valid;
  logic [7:0]     agent_reward_data;
  logic           agent_reward_ready;
  logic [N-1:0]   client_action_valid;
  logic [7:0]     client_action_data;
  logic [N-1:0]   client_action_ready;
  logic [N-1:0]   client_action_gready;
  logic [N-1:0]   client_reward_valid;
  logic [8*N-1:0] client_reward_data;
  logic [N-1:0]   client_reward_ready;

  action_arbiter #(.CLIENTS(N), .TIMEOUT(4), .PENALTY(8'h80)) dut (
    .clock(clock), .reset_n(reset_n),
    .client_req(client_req), .client_grant(client_grant),
    .agent_action_valid(agent_action_valid), .agent_action_data(agent_action_data),
    .agent_action_ready(agent_action_ready), .agent_action_gready(agent_action_gready),
    .agent_reward_valid(agent_reward_valid), .agent_reward_data(agent_reward_data),
    .agent_reward_ready(agent_reward_ready),
    .client_action_valid(client_action_valid), .client_action_data(client_action_data),
    .client_action_ready(client_action_ready), .client_action_gready(client_action_gready),
    .client_reward_valid(client_reward_valid), .client_reward_data(client_reward_data),
    .client_reward_ready(client_reward_ready)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;
  int m_last;   // reference: index of the previous winner

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first requester after the previous winner, with wrap-around
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx = (m_last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"},  client_grant, 0);
    chk({tag, "_cav"},    client_action_valid, 0);
    chk({tag, "_crr"},    client_reward_ready, 0);
    chk({tag, "_aar"},    agent_action_ready, 0);
    chk({tag, "_arv"},    agent_reward_valid, 0);
    chk({tag, "_gready"}, agent_action_gready, 0);
  endtask

  task automatic zero_inputs();
    client_req           = '0;
    agent_action_valid   = 1'b0;
    agent_action_data    = 8'h00;
    agent_reward_ready   = 1'b0;
    client_action_ready  = '0;
    client_action_gready = '0;
    client_reward_valid  = '0;
    client_reward_data   = '0;
  endtask

  // One full transaction, entered and left at a negedge with the DUT in IDLE
  task automatic run_txn(input logic [N-1:0] req, input logic [7:0] act,
                         input logic [7:0] rew, input bit rnd);
    int w;
    int n;
    bit hs;
    logic [N-1:0] oh;
    client_req = req;
    #1;
    chk_idle("pre");
    w = pick(req);
    m_last = w;
    oh = '0;
    oh[w] = 1'b1;
    @(negedge clock);
    // Requests are ignored outside IDLE; dropping them must not end the transaction
    client_req = rnd ? N'($urandom) : '0;
    n = 0;
    hs = 1'b0;
    while (!hs) begin
      agent_action_data    = act;
      agent_action_valid   = rnd ? 1'($urandom) : 1'b1;
      client_action_ready  = rnd ? N'($urandom) : oh;
      client_action_gready = N'($urandom);
      if (n >= 5) begin
        agent_action_valid    = 1'b1;
        client_action_ready[w] = 1'b1;
      end
      #1;
      chk("act_grant",  client_grant, oh);
      chk("act_cav",    client_action_valid, agent_action_valid ? oh : '0);
      chk("act_aar",    agent_action_ready, client_action_ready[w]);
      chk("act_gready", agent_action_gready, client_action_gready[w]);
      chk("act_data",   client_action_data, act);
      chk("act_arv",    agent_reward_valid, 0);
      chk("act_crr",    client_reward_ready, 0);
      hs = agent_action_valid & client_action_ready[w];
      @(negedge clock);
      n++;
    end
    agent_action_valid  = 1'b0;
    client_action_ready = '0;
    n = 0;
    hs = 1'b0;
    while (!hs) begin
      client_reward_valid = rnd ? N'($urandom) : {N{1'b1}};
      client_reward_data  = $urandom;
      client_reward_data[8*w +: 8] = rew;
      agent_reward_ready  = rnd ? 1'($urandom) : 1'b1;
      client_action_gready = N'($urandom);
      if (n >= 3) begin
        client_reward_valid[w] = 1'b1;
        agent_reward_ready     = 1'b1;
      end
      #1;
      chk("rew_grant",  client_grant, oh);
      chk("rew_arv",    agent_reward_valid, client_reward_valid[w]);
      chk("rew_data",   agent_reward_data, rew);
      chk("rew_crr",    client_reward_ready, agent_reward_ready ? oh : '0);
      chk("rew_cav",    client_action_valid, 0);
      chk("rew_aar",    agent_action_ready, 0);
      chk("rew_gready", agent_action_gready, client_action_gready[w]);
      hs = client_reward_valid[w] & agent_reward_ready;
      @(negedge clock);
      n++;
    end
    client_reward_valid  = '0;
    agent_reward_ready   = 1'b0;
    client_action_gready = '0;
    #1;
    chk_idle("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  initial begin
    int w;
    logic [N-1:0] oh;
    reset_n = 1'b0;
    zero_inputs();
    m_last = N - 1;
    @(negedge clock);
    @(negedge clock);
    chk_idle("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Continuous all-client requests: expected 0,1,2,3,0,1,2,3
    for (int t = 0; t < 8; t++) begin
      run_txn({N{1'b1}}, 8'(t), 8'(8'h20 + t), 1'b0);
    end

    // Single requester, fixed action/reward values
    run_txn(4'b0001, 8'h3c, 8'h10, 1'b0);

    // Grant to client 2 while other clients assert reward_valid
    run_txn(4'b0100, 8'h5a, 8'hf3, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(N'($urandom_range(1, (1 << N) - 1)), 8'($urandom), 8'($urandom), 1'b1);
    end

    // Asynchronous reset in the middle of REWARD
    client_req = {N{1'b1}};
    w = pick(client_req);
    m_last = w;
    oh = '0;
    oh[w] = 1'b1;
    @(negedge clock);
    client_req          = '0;
    agent_action_valid  = 1'b1;
    client_action_ready = oh;
    @(negedge clock);
    agent_action_valid  = 1'b0;
    client_action_ready = '0;
    client_reward_valid = {N{1'b1}};
    agent_reward_ready  = 1'b0;
    #1;
    chk("rst_pre_arv", agent_reward_valid, 1);
    agent_reward_ready = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_grant", client_grant, 0);
    chk("rst_arv",   agent_reward_valid, 0);
    chk("rst_crr",   client_reward_ready, 0);
    chk("rst_ard",   agent_reward_data, 0);
    @(negedge clock);
    zero_inputs();
    reset_n = 1'b1;
    m_last = N - 1;
    @(negedge clock);
    run_txn({N{1'b1}}, 8'h11, 8'h22, 1'b0);

    // Silent client in REWARD
    client_req = 4'b0010;
    w = pick(client_req);
    m_last = w;
    oh = '0;
    oh[w] = 1'b1;
    @(negedge clock);
    client_req          = '0;
    agent_action_valid  = 1'b1;
    client_action_ready = oh;
    @(negedge clock);
    agent_action_valid  = 1'b0;
    client_action_ready = '0;
    client_reward_valid = '0;
    agent_reward_ready  = 1'b1;
`ifdef ACTION_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("tmo_wait_arv", agent_reward_valid, 0);
      chk("tmo_wait_crr", client_reward_ready, oh);
      @(negedge clock);
    end
    agent_reward_ready = 1'b0;
    #1;
    chk("tmo_pen_arv", agent_reward_valid, 1);
    chk("tmo_pen_ard", agent_reward_data, 8'h80);
    chk("tmo_pen_crr", client_reward_ready, 0);
    @(negedge clock);
    client_reward_valid = oh;
    client_reward_data[8*w +: 8] = 8'h55;
    agent_reward_ready = 1'b1;
    #1;
    chk("tmo_late_arv", agent_reward_valid, 1);
    chk("tmo_late_ard", agent_reward_data, 8'h80);
    chk("tmo_late_crr", client_reward_ready, 0);
    @(negedge clock);
`else
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("wait_arv",   agent_reward_valid, 0);
      chk("wait_grant", client_grant, oh);
      @(negedge clock);
    end
    client_reward_valid = oh;
    client_reward_data[8*w +: 8] = 8'h55;
    #1;
    chk("wait_ard", agent_reward_data, 8'h55);
    chk("wait_crr", client_reward_ready, oh);
    @(negedge clock);
`endif
    client_reward_valid = '0;
    agent_reward_ready  = 1'b0;
    #1;
    chk_idle("end");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
